param_timer: RTL and testbench
==============================

PARAM_TIMER -- requirements
Module: param_timer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, meaning counter, top and load_val width in bits (2..32).
REQ-002 The block SHALL take parameter PRE_W, default 8, meaning prescaler width in bits (1..16).
REQ-003 The block SHALL use reset rst_n, asynchronous, active-low; clock clk.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  start/resume request pulse.
REQ-007 stop  input  1  stop request pulse.
REQ-008 dir_down  input  1  0 = count up, 1 = count down.
REQ-009 oneshot  input  1  0 = periodic, 1 = one-shot.
REQ-010 prescale  input  PRE_W  one count step every prescale+1 cycles.
REQ-011 top  input  WIDTH  period limit / reload value.
REQ-012 load  input  1  synchronous load of load_val into count.
REQ-013 load_val  input  WIDTH  value loaded into count.
REQ-014 irq_clr  input  1  clears irq.
REQ-015 count  output  WIDTH  current counter value.
REQ-016 tick  output  1  one-cycle terminal-event pulse.
REQ-017 irq  output  1  sticky terminal-event flag.
REQ-018 running  output  1  high while in state RUN.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on start; DONE->RUN on start; RUN->IDLE on stop; DONE->IDLE on stop; RUN->DONE on a terminal event with oneshot=1; RUN stays in RUN on a terminal event with oneshot=0.
REQ-020 stop SHALL win over start when both are asserted in the same cycle.
REQ-021 In RUN, prescaler pre_q SHALL increment each cycle and issue a step when pre_q >= prescale; on a step pre_q returns to 0.
REQ-022 pre_q SHALL clear on start and on load, and SHALL hold in IDLE and DONE.
REQ-023 Up mode: a step SHALL increment count, or if count >= top SHALL set count to 0 as a terminal event.
REQ-024 Down mode: a step SHALL decrement count, or if count == 0 SHALL set count to top as a terminal event.
REQ-025 Period SHALL be (top+1)*(prescale+1) cycles; top=0 SHALL give a terminal event on every step with count fixed at 0.
REQ-026 tick SHALL be registered and high exactly one cycle, coincident with the reloaded count value.
REQ-027 count SHALL hold in IDLE and DONE.
REQ-028 load SHALL take priority over a step in the same cycle, SHALL work in any state, and SHALL leave the state unchanged.
REQ-029 irq SHALL set on every terminal event and clear on irq_clr; set SHALL win over clear in the same cycle.
REQ-030 A change of dir_down, top or prescale during RUN SHALL take effect at the next step without a restart.

Reset
REQ-031 On rst_n low the block SHALL asynchronously enter IDLE with count=0, pre_q=0, tick=0, irq=0, running=0 (and pwm_out=0 when present).
REQ-032 A reset asserted mid-run SHALL abort immediately, with no tick or irq generated.

Configuration
REQ-033 With macro TIMER_PWM_EN defined, ports cmp (input, WIDTH) and pwm_out (output, 1) SHALL exist, and pwm_out SHALL register (running && count < cmp) each cycle.
REQ-034 Without TIMER_PWM_EN, cmp, pwm_out and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 WIDTH=8, prescale=0, top=3, up, periodic, start -> count 0,1,2,3,0,1…; tick each time count returns to 0, every 4 cycles; irq set.
REQ-036 prescale=2, top=3, up, periodic -> count advances every 3 cycles; tick every 12 cycles.
REQ-037 load_val=5 with load, then dir_down=1, oneshot=1, top=9, prescale=0, start -> count 5,4,3,2,1,0,9; one tick; DONE; running=0; count holds at 9.
REQ-038 load and step in the same cycle with load_val=0x80 -> count=0x80 and pre_q=0; irq_clr and tick in the same cycle -> irq stays 1.
REQ-039 start and stop asserted together in IDLE -> stays IDLE; rst_n pulsed low mid-RUN at count=2 -> count=0, IDLE, no tick.
REQ-040 With TIMER_PWM_EN, top=9, cmp=3 -> pwm_out high for 3 of every 10 cycles, one cycle after the matching count.

Source files
------------

// File: rtl/param_timer.sv
// param_timer: prescaled up/down timer with periodic and one-shot modes, tick pulse and sticky irq.
// Defining TIMER_PWM_EN adds the cmp input and a registered pwm_out output.
module param_timer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir_down,
    input  logic             oneshot,
    input  logic [PRE_W-1:0] prescale,
    input  logic [WIDTH-1:0] top,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             irq_clr,
`ifdef TIMER_PWM_EN
    input  logic [WIDTH-1:0] cmp,
    output logic             pwm_out,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             irq,
    output logic             running
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [PRE_W-1:0] pre_q, pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             step, term, start_ok;

    assign start_ok = start && !stop;
    assign running  = (state == RUN);

    // A load pre-empts the step entirely, so no terminal event can fire in that cycle.
    always_comb begin
        step      = (state == RUN) && !load && (pre_q >= prescale);
        term      = 1'b0;
        count_nxt = count;
        if (load) begin
            count_nxt = load_val;
        end else if (step) begin
            if (dir_down) begin
                if (count == '0) begin
                    count_nxt = top;
                    term      = 1'b1;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end else begin
                if (count >= top) begin
                    count_nxt = '0;
                    term      = 1'b1;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        pre_nxt = pre_q;
        if (load || start_ok || step) begin
            pre_nxt = '0;
        end else if (state == RUN) begin
            pre_nxt = pre_q + PRE_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                if (stop) state_nxt = IDLE;
                else if (term && oneshot) state_nxt = DONE;
            end
            DONE: begin
                if (stop) state_nxt = IDLE;
                else if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            pre_q <= '0;
            tick  <= 1'b0;
            irq   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            pre_q <= pre_nxt;
            tick  <= term;
            if (term) irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
        end
    end

`ifdef TIMER_PWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_out <= 1'b0;
        else        pwm_out <= running && (count < cmp);
    end
`endif

endmodule

// File: tb/tb_param_timer.sv
// Self-checking bench for param_timer: directed scenarios plus random stimulus against a cycle reference model.
// Build with TIMER_PWM_EN defined to also exercise the PWM output.
module tb_param_timer;

    localparam int WIDTH = 8;
    localparam int PRE_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0, stop = 1'b0, dir_down = 1'b0, oneshot = 1'b0;
    logic [PRE_W-1:0] prescale = '0;
    logic [WIDTH-1:0] top = '0, load_val = '0;
    logic             load = 1'b0, irq_clr = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tick, irq, running;
`ifdef TIMER_PWM_EN
    logic [WIDTH-1:0] cmp = '0;
    logic             pwm_out;
`endif

    param_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir_down(dir_down),
        .oneshot(oneshot), .prescale(prescale), .top(top), .load(load), .load_val(load_val),
        .irq_clr(irq_clr),
`ifdef TIMER_PWM_EN
        .cmp(cmp), .pwm_out(pwm_out),
`endif
        .count(count), .tick(tick), .irq(irq), .running(running)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 = idle, 1 = running, 2 = finished one-shot.
    int m_mode = 0, m_count = 0, m_pre = 0;
    bit m_tick = 0, m_irq = 0, m_pwm = 0;

    function automatic logic [WIDTH+2:0] exp_vec();
        return {WIDTH'(m_count), m_tick, m_irq, (m_mode == 1)};
    endfunction

    function automatic string obs_s();
        return $sformatf("count=%0d tick=%0b irq=%0b running=%0b", count, tick, irq, running);
    endfunction

    function automatic string exp_s();
        return $sformatf("count=%0d tick=%0b irq=%0b running=%0b", m_count, m_tick, m_irq, m_mode == 1);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_count = 0; m_pre = 0; m_tick = 0; m_irq = 0; m_pwm = 0;
    endtask

    // Predict the effect of the coming clock edge from the current inputs, then apply it 1ns after the edge.
    task automatic advance();
        int  nc = m_count, np = m_pre, nm = m_mode, lim = int'(top);
        bit  go = start && !stop;
        bit  stepping = (m_mode == 1) && !load && (m_pre >= int'(prescale));
        bit  term = 0;
        bit  npwm = 0;
        if (load) nc = int'(load_val);
        else if (stepping) begin
            if (!dir_down) begin
                if (m_count >= lim) begin nc = 0; term = 1; end
                else nc = m_count + 1;
            end else begin
                if (m_count == 0) begin nc = lim; term = 1; end
                else nc = m_count - 1;
            end
        end
        if (load || go || stepping) np = 0;
        else if (m_mode == 1) np = m_pre + 1;
        if (stop) nm = 0;
        else if (go && m_mode != 1) nm = 1;
        else if (m_mode == 1 && term && oneshot) nm = 2;
`ifdef TIMER_PWM_EN
        npwm = (m_mode == 1) && (m_count < int'(cmp));
`endif
        @(posedge clk);
        #1;
        m_count = nc; m_pre = np; m_mode = nm; m_tick = term; m_pwm = npwm;
        if (term) m_irq = 1;
        else if (irq_clr) m_irq = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #12;
        vectors++;
        if ({count, tick, irq, running} !== '0)
            begin miscompares++; $display("FAIL reset_state: got %s, want all zero", obs_s()); end
        rst_n = 1'b1;
        advance();
        vectors++;
        if ({count, tick, irq, running} !== exp_vec())
            begin miscompares++; $display("FAIL reset_idle: got %s, want %s", obs_s(), exp_s()); end
    endtask

    task automatic test_up_periodic();
        int ticks = 0;
        top = 8'd3; prescale = '0; dir_down = 1'b0; oneshot = 1'b0; start = 1'b1;
        advance();
        start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            advance();
            ticks += int'(tick);
            vectors++;
            if (count !== WIDTH'(k % 4) || tick !== (k % 4 == 0) || running !== 1'b1 ||
                {count, tick, irq, running} !== exp_vec())
                begin miscompares++; $display("FAIL up_periodic k=%0d: got %s, want count=%0d tick=%0b (%s)", k, obs_s(), k % 4, k % 4 == 0, exp_s()); end
        end
        vectors++;
        if (ticks != 4 || irq !== 1'b1)
            begin miscompares++; $display("FAIL up_periodic_ticks: got %0d ticks irq=%0b, want 4 ticks irq=1", ticks, irq); end
        stop = 1'b1;
        advance();
        stop = 1'b0;
        vectors++;
        if (running !== 1'b0 || {count, tick, irq, running} !== exp_vec())
            begin miscompares++; $display("FAIL stop_to_idle: got %s, want %s", obs_s(), exp_s()); end
    endtask

    task automatic test_prescale();
        int ticks = 0;
        irq_clr = 1'b1; load = 1'b1; load_val = '0;
        advance();
        irq_clr = 1'b0; load = 1'b0;
        top = 8'd3; prescale = 8'd2; start = 1'b1;
        advance();
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            advance();
            ticks += int'(tick);
            vectors++;
            if (count !== WIDTH'((k / 3) % 4) || tick !== (k % 12 == 0) ||
                {count, tick, irq, running} !== exp_vec())
                begin miscompares++; $display("FAIL prescale k=%0d: got %s, want count=%0d tick=%0b", k, obs_s(), (k / 3) % 4, k % 12 == 0); end
        end
        vectors++;
        if (ticks != 2)
            begin miscompares++; $display("FAIL prescale_ticks: got %0d, want 2", ticks); end
        stop = 1'b1;
        advance();
        stop = 1'b0;
    endtask

    task automatic test_oneshot_down();
        int seq[6] = '{4, 3, 2, 1, 0, 9};
        int ticks = 0;
        load = 1'b1; load_val = 8'd5;
        advance();
        load = 1'b0;
        dir_down = 1'b1; oneshot = 1'b1; top = 8'd9; prescale = '0; start = 1'b1;
        advance();
        start = 1'b0;
        vectors++;
        if (count !== 8'd5 || running !== 1'b1)
            begin miscompares++; $display("FAIL oneshot_start: got %s, want count=5 running=1", obs_s()); end
        for (int k = 1; k <= 10; k++) begin
            advance();
            ticks += int'(tick);
            vectors++;
            if (count !== WIDTH'(k <= 6 ? seq[k-1] : 9) || running !== (k < 6) || tick !== (k == 6) ||
                {count, tick, irq, running} !== exp_vec())
                begin miscompares++; $display("FAIL oneshot_down k=%0d: got %s, want %s", k, obs_s(), exp_s()); end
        end
        vectors++;
        if (ticks != 1)
            begin miscompares++; $display("FAIL oneshot_ticks: got %0d, want 1", ticks); end
    endtask

    task automatic test_load_step();
        int guard = 0;
        stop = 1'b1;
        advance();
        stop = 1'b0; irq_clr = 1'b1;
        dir_down = 1'b0; oneshot = 1'b0; top = 8'd3; prescale = '0; start = 1'b1;
        advance();
        start = 1'b0; irq_clr = 1'b0;
        advance();
        advance();
        load = 1'b1; load_val = 8'h80;
        advance();
        load = 1'b0; prescale = 8'd2;
        vectors++;
        if (count !== 8'h80 || tick !== 1'b0 || {count, tick, irq, running} !== exp_vec())
            begin miscompares++; $display("FAIL load_over_step: got %s, want count=128 tick=0", obs_s()); end
        for (int k = 1; k <= 3; k++) begin
            advance();
            vectors++;
            if (count !== (k < 3 ? 8'h80 : 8'h00) || tick !== (k == 3) ||
                {count, tick, irq, running} !== exp_vec())
                begin miscompares++; $display("FAIL load_clears_pre k=%0d: got %s, want %s", k, obs_s(), exp_s()); end
        end
        prescale = '0;
        while (!(m_mode == 1 && m_count == 3) && guard < 20) begin
            advance();
            guard++;
            vectors++;
            if ({count, tick, irq, running} !== exp_vec())
                begin miscompares++; $display("FAIL wait_top: got %s, want %s", obs_s(), exp_s()); end
        end
        vectors++;
        if (guard >= 20)
            begin miscompares++; $display("FAIL wait_top_timeout: got count=%0d, want 3 within 20 cycles", count); end
        irq_clr = 1'b1;
        advance();
        vectors++;
        if (tick !== 1'b1 || irq !== 1'b1)
            begin miscompares++; $display("FAIL irq_set_wins: got tick=%0b irq=%0b, want tick=1 irq=1", tick, irq); end
        advance();
        irq_clr = 1'b0;
        vectors++;
        if (irq !== 1'b0 || {count, tick, irq, running} !== exp_vec())
            begin miscompares++; $display("FAIL irq_clr: got %s, want irq=0 (%s)", obs_s(), exp_s()); end
    endtask

    task automatic test_start_stop();
        stop = 1'b1;
        advance();
        start = 1'b1;
        advance();
        start = 1'b0; stop = 1'b0;
        vectors++;
        if (running !== 1'b0 || {count, tick, irq, running} !== exp_vec())
            begin miscompares++; $display("FAIL stop_wins: got %s, want running=0", obs_s()); end
        load = 1'b1; load_val = '0; top = 8'd9; prescale = '0; dir_down = 1'b0; start = 1'b1;
        advance();
        load = 1'b0; start = 1'b0;
        advance();
        advance();
        vectors++;
        if (count !== 8'd2 || running !== 1'b1)
            begin miscompares++; $display("FAIL pre_reset_count: got %s, want count=2 running=1", obs_s()); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== '0 || running !== 1'b0 || tick !== 1'b0 || irq !== 1'b0)
            begin miscompares++; $display("FAIL async_reset: got %s, want all zero", obs_s()); end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        advance();
        vectors++;
        if ({count, tick, irq, running} !== '0 || {count, tick, irq, running} !== exp_vec())
            begin miscompares++; $display("FAIL after_reset: got %s, want all zero", obs_s()); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            start    = ($urandom_range(0, 99) < 8);
            stop     = ($urandom_range(0, 99) < 3);
            load     = ($urandom_range(0, 99) < 4);
            irq_clr  = ($urandom_range(0, 99) < 10);
            load_val = WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 99) < 5) dir_down = ~dir_down;
            if ($urandom_range(0, 99) < 5) oneshot  = ~oneshot;
            if ($urandom_range(0, 99) < 4) top      = WIDTH'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 4) prescale = PRE_W'($urandom_range(0, 3));
`ifdef TIMER_PWM_EN
            if ($urandom_range(0, 99) < 4) cmp      = WIDTH'($urandom_range(0, 9));
`endif
            advance();
            vectors++;
            if ({count, tick, irq, running} !== exp_vec())
                begin miscompares++; $display("FAIL random n=%0d: got %s, want %s", n, obs_s(), exp_s()); end
        end
        start = 1'b0; stop = 1'b0; load = 1'b0; irq_clr = 1'b0;
    endtask

`ifdef TIMER_PWM_EN
    task automatic test_pwm();
        int high = 0;
        stop = 1'b1;
        advance();
        stop = 1'b0;
        load = 1'b1; load_val = '0; top = 8'd9; cmp = 8'd3; prescale = '0;
        dir_down = 1'b0; oneshot = 1'b0; start = 1'b1;
        advance();
        load = 1'b0; start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            advance();
            if (k > 10) high += int'(pwm_out);
            vectors++;
            if (pwm_out !== m_pwm || {count, tick, irq, running} !== exp_vec())
                begin miscompares++; $display("FAIL pwm k=%0d: got pwm=%0b %s, want pwm=%0b %s", k, pwm_out, obs_s(), m_pwm, exp_s()); end
        end
        vectors++;
        if (high != 6)
            begin miscompares++; $display("FAIL pwm_duty: got %0d high cycles in 20, want 6", high); end
    endtask
`endif

    initial begin
        test_reset();
        test_up_periodic();
        test_prescale();
        test_oneshot_down();
        test_load_step();
        test_start_stop();
`ifdef TIMER_PWM_EN
        test_pwm();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
